// File: rtl/aclk_pkg.sv
// Shared state encoding and key constants for the gen2 alarm-clock controller.
package aclk_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_ENTRY        = 3'd1,
    KEY_STORED       = 3'd2,
    SHOW_ALARM       = 3'd3,
    SET_ALARM_TIME   = 3'd4,
    SET_CURRENT_TIME = 3'd5,
    KEY_WAITED       = 3'd6
  } state_t;

  localparam logic [3:0] NOKEY_CODE = 4'd10;

  // Timeout only runs while the user is in the middle of typing an entry.
  function automatic logic in_entry(input state_t s);
    return (s == KEY_ENTRY) || (s == KEY_WAITED);
  endfunction

endpackage

// File: rtl/aclk_timeout_timer.sv
// Counts one_second pulses while enabled; flags the pulse that completes TIMEOUT_SEC.
module aclk_timeout_timer #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic one_second,
  input  logic enable,
  input  logic clear,
  output logic time_out
);

  localparam int TW = $clog2(TIMEOUT_SEC);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_SEC - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear || !enable) count <= '0;
    else if (one_second)           count <= count + TW'(1);
  end

  assign time_out = enable & one_second & (count == LAST);

endmodule

// File: rtl/aclk_ctrl_gen2.sv
// Keypad/mode controller: Moore FSM gating digit shifts and time/alarm commits.
module aclk_ctrl_gen2
  import aclk_pkg::*;
#(
  parameter int         TIMEOUT_SEC = 10,
  parameter int         NUM_ALARMS  = 2,
  parameter int         DIGITS      = 4,
  parameter logic [3:0] NOKEY       = NOKEY_CODE,
  parameter int         SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int        DCW         = $clog2(DIGITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  one_second,
  input  logic                  alarm_button,
  input  logic                  time_button,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [3:0]            key,
  output logic                  show_new_time,
  output logic                  show_a,
  output logic [NUM_ALARMS-1:0] load_new_a,
  output logic                  load_new_c,
  output logic                  reset_count,
  output logic                  shift,
  output logic [SEL_W-1:0]      alarm_idx,
  output logic [DCW-1:0]        digit_cnt
);

  localparam logic [SEL_W:0] NA_LIM = (SEL_W + 1)'(NUM_ALARMS);
  localparam logic [DCW-1:0] DMAX   = DCW'(DIGITS);

  state_t           state, state_nxt;
  logic [DCW-1:0]   cnt_nxt;
  logic [SEL_W-1:0] idx_nxt, sel_eff;
  logic             time_out, key_hit, full;

  assign key_hit = (key != NOKEY);
  assign full    = (digit_cnt == DMAX);
  assign sel_eff = ({1'b0, alarm_sel} < NA_LIM) ? alarm_sel : '0;

  aclk_timeout_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .one_second (one_second),
    .enable     (in_entry(state)),
    .clear      (state_nxt != state),
    .time_out   (time_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SHOW_TIME;
      digit_cnt <= '0;
      alarm_idx <= '0;
    end else begin
      state     <= state_nxt;
      digit_cnt <= cnt_nxt;
      alarm_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = digit_cnt;
    idx_nxt   = alarm_idx;
    case (state)
      SHOW_TIME: begin
        if (alarm_button) begin
          state_nxt = SHOW_ALARM;
          idx_nxt   = sel_eff;
        end else if (key_hit) begin
          state_nxt = KEY_STORED;
          cnt_nxt   = DCW'(1);
        end
      end
      KEY_STORED: state_nxt = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_hit) state_nxt = KEY_ENTRY;
        else if (time_out) begin
          state_nxt = SHOW_TIME;
          cnt_nxt   = '0;
        end
      end
      KEY_ENTRY: begin
        if (time_out) begin
          state_nxt = SHOW_TIME;
          cnt_nxt   = '0;
        end else if (alarm_button && full) begin
          state_nxt = SET_ALARM_TIME;
          idx_nxt   = sel_eff;
        end else if (time_button && full) begin
          state_nxt = SET_CURRENT_TIME;
        end else if (key_hit) begin
          // Extra keys keep rolling into the buffer; the count just pins at DIGITS.
          state_nxt = KEY_STORED;
          cnt_nxt   = full ? DMAX : digit_cnt + DCW'(1);
        end
      end
      SHOW_ALARM: if (!alarm_button) state_nxt = SHOW_TIME;
      SET_ALARM_TIME, SET_CURRENT_TIME: begin
        state_nxt = SHOW_TIME;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = SHOW_TIME;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are masked while reset is high so a commit state caught by reset never strobes.
  always_comb begin
    show_new_time = 1'b0;
    show_a        = 1'b0;
    load_new_a    = '0;
    load_new_c    = 1'b0;
    reset_count   = 1'b0;
    shift         = 1'b0;
    if (!reset) begin
      show_new_time = (state == KEY_ENTRY) || (state == KEY_STORED) || (state == KEY_WAITED);
      show_a        = (state == SHOW_ALARM);
      shift         = (state == KEY_STORED);
      load_new_c    = (state == SET_CURRENT_TIME);
      reset_count   = (state == SET_CURRENT_TIME);
      if (state == SET_ALARM_TIME) load_new_a[alarm_idx] = 1'b1;
    end
  end

endmodule
